// File: rtl/serial_sub_pkg.sv
// ---------------------------------------------------------------------------
// serial_sub_pkg
//   Shared definitions for the bit-serial subtractor.
//   - state_e       : controller states (IDLE / SHIFT / DONE)
//   - DEFAULT_WIDTH : default operand width
//   - MIN_WIDTH / MAX_WIDTH : legal operand width range
// ---------------------------------------------------------------------------
package serial_sub_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned MIN_WIDTH     = 2;
    localparam int unsigned MAX_WIDTH     = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage : serial_sub_pkg

// File: rtl/serial_subtractor_full_subtractor.sv
// ---------------------------------------------------------------------------
// half_subtractor
//   One-bit half subtractor: d = a - b, bo = borrow out.
//   Ports: a, b (in); d, bo (out).
//
// full_subtractor
//   One-bit full subtractor built from two half subtractors; the two
//   partial borrows are ORed (they can never both be set).
//   Ports: a, b, bin (in); d, bout (out).
// ---------------------------------------------------------------------------
module half_subtractor (
    input  logic a,
    input  logic b,
    output logic d,
    output logic bo
);

    assign d  = a ^ b;
    assign bo = ~a & b;

endmodule : half_subtractor

module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d1;
    logic b1;
    logic b2;

    half_subtractor u_hs_ab (
        .a  (a),
        .b  (b),
        .d  (d1),
        .bo (b1)
    );

    // Second stage subtracts the incoming borrow from the partial difference.
    half_subtractor u_hs_bin (
        .a  (d1),
        .b  (bin),
        .d  (d),
        .bo (b2)
    );

    assign bout = b1 | b2;

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor, D = A - B, LSB first, one bit per clock.
//   Operands are taken on a valid/ready handshake, the result is held on a
//   valid/ready handshake until taken. No overlap between operations.
//
//   Ports:
//     clk       : rising-edge clock
//     rst       : synchronous active-high reset
//     in_valid  : operands A/B present
//     in_ready  : block can accept operands (IDLE and not in reset)
//     A, B      : minuend / subtrahend
//     out_valid : result valid (DONE)
//     out_ready : consumer accepts result
//     D         : difference A - B mod 2^WIDTH
//     Bout      : final borrow, 1 iff A < B unsigned
//     OVF       : signed (two's complement) overflow
// ---------------------------------------------------------------------------
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             OVF
);

    localparam int unsigned        CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q,  state_d;
    logic [WIDTH-1:0]   a_sr_q,   a_sr_d;
    logic [WIDTH-1:0]   b_sr_q,   b_sr_d;
    logic [WIDTH-1:0]   d_sr_q,   d_sr_d;
    logic               borrow_q, borrow_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               a_msb_q,  a_msb_d;
    logic               b_msb_q,  b_msb_d;
    logic               ovf_q,    ovf_d;

    logic               cell_d;
    logic               cell_bo;

    // Single shared bit cell working on the current LSBs and stored borrow.
    full_subtractor u_cell (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .bin  (borrow_q),
        .d    (cell_d),
        .bout (cell_bo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            d_sr_q   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            d_sr_q   <= d_sr_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        d_sr_d   = d_sr_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            IDLE: begin
                // in_ready is implied here: reset forces the register path.
                if (in_valid) begin
                    a_sr_d   = A;
                    b_sr_d   = B;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    a_msb_d  = A[WIDTH-1];
                    b_msb_d  = B[WIDTH-1];
                    state_d  = SHIFT;
                end
            end

            SHIFT: begin
                d_sr_d   = {cell_d, d_sr_q[WIDTH-1:1]};
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                borrow_d = cell_bo;
                if (cnt_q == CNT_LAST) begin
                    // Overflow only possible for operands of differing sign,
                    // and then shows as a result sign different from A's.
                    ovf_d   = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are forced to their cleared values while reset is asserted.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE) && !rst;
    assign D         = rst ? '0 : d_sr_q;
    assign Bout      = rst ? 1'b0 : borrow_q;
    assign OVF       = rst ? 1'b0 : ovf_q;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] D;
    logic         Bout;
    logic         OVF;

    int unsigned total  = 0;
    int unsigned passed = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .Bout      (Bout),
        .OVF       (OVF)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain integer arithmetic on the operand values.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] ed, output logic eb, output logic eo);
        longint ua, ub, sa, sb, sd, m;
        m  = longint'(1) << W;
        ua = longint'(a);
        ub = longint'(b);
        ed = W'((ua - ub + m) % m);
        eb = (ua < ub);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        sd = sa - sb;
        eo = (sd > m / 2 - 1) || (sd < -(m / 2));
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        logic [W-1:0] ed;
        logic         eb, eo;
        int           n;
        model(a, b, ed, eb, eo);
        n = 0;
        while (!in_ready && n < 10) begin
            tick();
            n++;
        end
        check("ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        A = a;
        B = b;
        tick();
        in_valid = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        n = 0;
        while (!out_valid && n < int'(W) + 5) begin
            tick();
            n++;
        end
        check("latency", 32'(n), 32'(W));
        check("D", 32'(D), 32'(ed));
        check("Bout", 32'(Bout), 32'(eb));
        check("OVF", 32'(OVF), 32'(eo));
        check("ready_in_done", 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_D", 32'(D), 32'(ed));
            check("hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("valid_after_take", 32'(out_valid), 32'd0);
        check("D_retained", 32'(D), 32'(ed));
        check("Bout_retained", 32'(Bout), 32'(eb));
        check("ready_after_take", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [W-1:0] ed;
        logic         eb, eo;
        logic [W-1:0] exp_d[$];
        logic         exp_b[$];
        int           acc[$];
        int           nres;
        logic         acc_now;

        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] exp_d[$];
        logic         exp_b[$];
        logic [W-1:0] ed;
        logic         eb, eo;
        int           acc[$];
        int           nres;
        logic         acc_now;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_D", 32'(D), 32'd0);
        check("rst_Bout", 32'(Bout), 32'd0);
        check("rst_OVF", 32'(OVF), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        tick();

        // Directed cases
        do_op(8'd100, 8'd37, 0);
        do_op(8'd5,   8'd9,  0);
        do_op(8'h80,  8'h01, 1);
        do_op(8'h7F,  8'hFF, 0);
        do_op(8'hAA,  8'h55, 5);
        do_op(8'h3C,  8'h3C, 0);

        // Reset part way through shifting: rst sampled on shift edge 4.
        in_valid = 1'b1;
        A = 8'd200;
        B = 8'd1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_D", 32'(D), 32'd0);
        check("midrst_in_ready_after", 32'(in_ready), 32'd1);
        do_op(8'd3, 8'd3, 0);

        // out_ready high outside DONE must be ignored
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        do_op(8'd0, 8'd255, 2);

        // Back-to-back with in_valid and out_ready held high
        model(8'd10, 8'd4, ed, eb, eo);
        exp_d.push_back(ed);
        exp_b.push_back(eb);
        model(8'd4, 8'd10, ed, eb, eo);
        exp_d.push_back(ed);
        exp_b.push_back(eb);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        A = 8'd10;
        B = 8'd4;
        nres = 0;
        for (int c = 0; c < 60 && nres < 2; c++) begin
            acc_now = in_valid && in_ready;
            if (out_valid) begin
                check("b2b_D", 32'(D), 32'(exp_d[nres]));
                check("b2b_Bout", 32'(Bout), 32'(exp_b[nres]));
                nres++;
            end
            tick();
            if (acc_now) begin
                acc.push_back(c);
                if (acc.size() == 1) begin
                    A = 8'd4;
                    B = 8'd10;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_results", 32'(nres), 32'd2);
        check("b2b_accepts", 32'(acc.size()), 32'd2);
        if (acc.size() == 2)
            check("b2b_interval", 32'(acc[1] - acc[0]), 32'(W + 2));
        tick();

        // Random operands and backpressure
        for (int i = 0; i < 20; i++) begin
            do_op(W'($urandom), W'($urandom), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_serial_subtractor
